uart_ahb_fifo: RTL and testbench

UART_AHB_FIFO -- requirements
Module: uart_ahb_fifo

---
 rtl/uart_ahb_fifo.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 tb/tb_uart_ahb_fifo.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_ahb_fifo.sv
// rtl/uart_ahb_fifo.sv - UART with a zero-wait-state AHB-style register port and TX/RX FIFOs

`ifndef AHB_DATA_WIDTH
`define AHB_DATA_WIDTH 32
`endif
`ifndef AHB_ADDR_WIDTH
`define AHB_ADDR_WIDTH 32
`endif

module uart_ahb_fifo #(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd868,
  parameter int          DATA_BITS   = 8
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [`AHB_DATA_WIDTH-1:0] hwdata,
  input  logic [`AHB_ADDR_WIDTH-1:0] haddr,
  input  logic                       hsel,
  input  logic                       hwrite,
  output logic                       hready,
  output logic                       hresp,
  output logic [`AHB_DATA_WIDTH-1:0] hrdata,
  input  logic                       rx_pin,
  output logic                       tx_pin,
  output logic                       irq
);

  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
  localparam logic [2:0]  LAST_BIT = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  // ---------------------------------------------------------------------------
  // Register port decode
  // ---------------------------------------------------------------------------
  logic       wr_en, rd_en;
  logic [1:0] reg_sel;
  logic       tx_push, rx_pop;
  logic [2:0] clr_bits;
  logic       unused_bus_bits;

  assign hready   = 1'b1;
  assign hresp    = 1'b0;
  assign wr_en    = hsel & hwrite;
  assign rd_en    = hsel & ~hwrite;
  assign reg_sel  = haddr[3:2];
  assign tx_push  = wr_en & (reg_sel == 2'd0);
  assign rx_pop   = rd_en & (reg_sel == 2'd0);
  assign clr_bits = (wr_en && reg_sel == 2'd3) ? hwdata[2:0] : 3'b000;
  assign unused_bus_bits = ^{hwdata[`AHB_DATA_WIDTH-1:20], haddr[`AHB_ADDR_WIDTH-1:4], haddr[1:0]};

  logic [19:0] ctrl_q, ctrl_d;
  logic [15:0] div_eff;

  // Frame timing never goes below 4 clocks per bit so the RX half-bit point stays meaningful
  assign div_eff = (ctrl_q[15:0] < 16'd4) ? 16'd4 : ctrl_q[15:0];

  // CTRL holds the programmed settings; each FSM snapshots them at its own frame start
  always_comb begin
    ctrl_d = ctrl_q;
    if (wr_en && reg_sel == 2'd2) ctrl_d = hwdata[19:0];
  end

  // CTRL register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ctrl_q <= {4'b0000, DEFAULT_DIV};
    else       ctrl_q <= ctrl_d;
  end

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_BITS-1:0] txf_mem_q [FIFO_DEPTH];
  logic [AW:0]          txf_wr_q, txf_wr_d, txf_rd_q, txf_rd_d;
  logic                 tx_full, tx_empty, tx_pop;
  logic [DATA_BITS-1:0] tx_head;

  assign tx_full  = (txf_wr_q[AW] != txf_rd_q[AW]) && (txf_wr_q[AW-1:0] == txf_rd_q[AW-1:0]);
  assign tx_empty = (txf_wr_q == txf_rd_q);
  assign tx_head  = txf_mem_q[txf_rd_q[AW-1:0]];

  // Push is judged against the pre-pop fullness, so a push on full is dropped even with a pop
  always_comb begin
    txf_wr_d = txf_wr_q;
    txf_rd_d = txf_rd_q;
    if (tx_push && !tx_full) txf_wr_d = txf_wr_q + PTR_ONE;
    if (tx_pop)              txf_rd_d = txf_rd_q + PTR_ONE;
  end

  // TX FIFO pointers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      txf_wr_q <= '0;
      txf_rd_q <= '0;
    end else begin
      txf_wr_q <= txf_wr_d;
      txf_rd_q <= txf_rd_d;
    end
  end

  // TX FIFO storage
  always_ff @(posedge clk) begin
    if (tx_push && !tx_full) txf_mem_q[txf_wr_q[AW-1:0]] <= hwdata[DATA_BITS-1:0];
  end

  // ---------------------------------------------------------------------------
  // RX FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_BITS-1:0] rxf_mem_q [FIFO_DEPTH];
  logic [AW:0]          rxf_wr_q, rxf_wr_d, rxf_rd_q, rxf_rd_d;
  logic                 rx_full, rx_empty, rx_push;
  logic [DATA_BITS-1:0] rx_head, rx_shift_q;
  logic [AW:0]          rx_count;
  logic [7:0]           rx_count8;

  assign rx_full   = (rxf_wr_q[AW] != rxf_rd_q[AW]) && (rxf_wr_q[AW-1:0] == rxf_rd_q[AW-1:0]);
  assign rx_empty  = (rxf_wr_q == rxf_rd_q);
  assign rx_head   = rx_empty ? '0 : rxf_mem_q[rxf_rd_q[AW-1:0]];
  assign rx_count  = rxf_wr_q - rxf_rd_q;
  assign rx_count8 = 8'(rx_count);

  // Reads of an empty FIFO leave the pointers alone
  always_comb begin
    rxf_wr_d = rxf_wr_q;
    rxf_rd_d = rxf_rd_q;
    if (rx_push && !rx_full) rxf_wr_d = rxf_wr_q + PTR_ONE;
    if (rx_pop && !rx_empty) rxf_rd_d = rxf_rd_q + PTR_ONE;
  end

  // RX FIFO pointers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rxf_wr_q <= '0;
      rxf_rd_q <= '0;
    end else begin
      rxf_wr_q <= rxf_wr_d;
      rxf_rd_q <= rxf_rd_d;
    end
  end

  // RX FIFO storage
  always_ff @(posedge clk) begin
    if (rx_push && !rx_full) rxf_mem_q[rxf_wr_q[AW-1:0]] <= rx_shift_q;
  end

  // ---------------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------------
  uart_state_e          tx_state_q, tx_state_d;
  logic [15:0]          tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [2:0]           tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_par_q, tx_par_d, tx_par_en_q, tx_par_en_d;
  logic                 tx_pin_q, tx_pin_d;
  logic                 tx_bit_end, tx_load;

  assign tx_bit_end = (tx_cnt_q == tx_div_q - 16'd1);

  // TX next state; tx_pin_d is the line level for the next cycle so the pin comes straight off a flop
  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q;
    tx_bit_d    = tx_bit_q;
    tx_shift_d  = tx_shift_q;
    tx_par_d    = tx_par_q;
    tx_div_d    = tx_div_q;
    tx_par_en_d = tx_par_en_q;
    tx_pin_d    = tx_pin_q;
    tx_pop      = 1'b0;
    tx_load     = 1'b0;
    case (tx_state_q)
      ST_IDLE: begin
        tx_pin_d = 1'b1;
        if (!tx_empty) tx_load = 1'b1;
      end
      ST_START: begin
        if (tx_bit_end) begin
          tx_state_d = ST_DATA;
          tx_cnt_d   = 16'd0;
          tx_bit_d   = 3'd0;
          tx_pin_d   = tx_shift_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      ST_DATA: begin
        if (tx_bit_end) begin
          tx_cnt_d = 16'd0;
          if (tx_bit_q == LAST_BIT) begin
            if (tx_par_en_q) begin
              tx_state_d = ST_PARITY;
              tx_pin_d   = tx_par_q;
            end else begin
              tx_state_d = ST_STOP;
              tx_pin_d   = 1'b1;
            end
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = tx_shift_q >> 1;
            tx_pin_d   = tx_shift_d[0];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      ST_PARITY: begin
        if (tx_bit_end) begin
          tx_state_d = ST_STOP;
          tx_cnt_d   = 16'd0;
          tx_pin_d   = 1'b1;
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      ST_STOP: begin
        if (tx_bit_end) begin
          if (!tx_empty) begin
            tx_load = 1'b1;
          end else begin
            tx_state_d = ST_IDLE;
            tx_pin_d   = 1'b1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      default: begin
        tx_state_d = ST_IDLE;
        tx_pin_d   = 1'b1;
      end
    endcase
    // Frame start: pop the head and freeze the frame settings for its whole duration
    if (tx_load) begin
      tx_pop      = 1'b1;
      tx_state_d  = ST_START;
      tx_cnt_d    = 16'd0;
      tx_shift_d  = tx_head;
      tx_par_d    = (^tx_head) ^ ctrl_q[17];
      tx_div_d    = div_eff;
      tx_par_en_d = ctrl_q[16];
      tx_pin_d    = 1'b0;
    end
  end

  // TX state register; reset drives the line idle immediately
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_state_q  <= ST_IDLE;
      tx_cnt_q    <= 16'd0;
      tx_bit_q    <= 3'd0;
      tx_shift_q  <= '0;
      tx_par_q    <= 1'b0;
      tx_div_q    <= 16'd4;
      tx_par_en_q <= 1'b0;
      tx_pin_q    <= 1'b1;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
      tx_par_q    <= tx_par_d;
      tx_div_q    <= tx_div_d;
      tx_par_en_q <= tx_par_en_d;
      tx_pin_q    <= tx_pin_d;
    end
  end

  assign tx_pin = tx_pin_q;

  // ---------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------
  logic                 rx_s1_q, rx_s2_q, rx_s3_q;
  uart_state_e          rx_state_q, rx_state_d;
  logic [15:0]          rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
  logic [2:0]           rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_d;
  logic                 rx_par_en_q, rx_par_en_d, rx_par_odd_q, rx_par_odd_d;
  logic                 rx_bit_end, set_perr, set_ferr, set_ovf;

  // Two-flop synchronizer plus one history flop for falling-edge detection
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_s3_q <= 1'b1;
    end else begin
      rx_s1_q <= rx_pin;
      rx_s2_q <= rx_s1_q;
      rx_s3_q <= rx_s2_q;
    end
  end

  assign rx_bit_end = (rx_cnt_q == rx_div_q - 16'd1);

  // RX next state: half a bit into START confirms the start bit, then one sample per bit period
  always_comb begin
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q;
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    rx_div_d     = rx_div_q;
    rx_par_en_d  = rx_par_en_q;
    rx_par_odd_d = rx_par_odd_q;
    rx_push      = 1'b0;
    set_perr     = 1'b0;
    set_ferr     = 1'b0;
    case (rx_state_q)
      ST_IDLE: begin
        if (rx_s3_q && !rx_s2_q) begin
          rx_state_d   = ST_START;
          rx_cnt_d     = 16'd0;
          rx_div_d     = div_eff;
          rx_par_en_d  = ctrl_q[16];
          rx_par_odd_d = ctrl_q[17];
        end
      end
      ST_START: begin
        if (rx_cnt_q == {1'b0, rx_div_q[15:1]} - 16'd1) begin
          rx_cnt_d   = 16'd0;
          rx_bit_d   = 3'd0;
          rx_state_d = rx_s2_q ? ST_IDLE : ST_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      ST_DATA: begin
        if (rx_bit_end) begin
          rx_cnt_d   = 16'd0;
          rx_shift_d = {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
          if (rx_bit_q == LAST_BIT) rx_state_d = rx_par_en_q ? ST_PARITY : ST_STOP;
          else                      rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      ST_PARITY: begin
        if (rx_bit_end) begin
          rx_cnt_d   = 16'd0;
          rx_state_d = ST_STOP;
          if (rx_s2_q != ((^rx_shift_q) ^ rx_par_odd_q)) set_perr = 1'b1;
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      ST_STOP: begin
        if (rx_bit_end) begin
          rx_cnt_d   = 16'd0;
          rx_state_d = ST_IDLE;
          if (!rx_s2_q) set_ferr = 1'b1;
          else          rx_push  = 1'b1;
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      default: rx_state_d = ST_IDLE;
    endcase
  end

  // RX state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_state_q   <= ST_IDLE;
      rx_cnt_q     <= 16'd0;
      rx_bit_q     <= 3'd0;
      rx_shift_q   <= '0;
      rx_div_q     <= 16'd4;
      rx_par_en_q  <= 1'b0;
      rx_par_odd_q <= 1'b0;
    end else begin
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      rx_div_q     <= rx_div_d;
      rx_par_en_q  <= rx_par_en_d;
      rx_par_odd_q <= rx_par_odd_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky status flags, status word, read mux, interrupt
  // ---------------------------------------------------------------------------
  logic ovf_q, ovf_d, perr_q, perr_d, ferr_q, ferr_d;
  logic [15:0] status;

  assign set_ovf = rx_push & rx_full;

  // A new event in the same cycle as its CLR keeps the flag set
  always_comb begin
    ovf_d  = set_ovf  | (ovf_q  & ~clr_bits[0]);
    perr_d = set_perr | (perr_q & ~clr_bits[1]);
    ferr_d = set_ferr | (ferr_q & ~clr_bits[2]);
  end

  // Sticky flag registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf_q  <= 1'b0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      ovf_q  <= ovf_d;
      perr_q <= perr_d;
      ferr_q <= ferr_d;
    end
  end

  assign status = {rx_count8, ferr_q, perr_q, ovf_q, (tx_state_q != ST_IDLE),
                   rx_empty, rx_full, tx_empty, tx_full};

  // Read data is combinational from the address and forced to 0 while in reset
  always_comb begin
    hrdata = '0;
    if (rd_en && rstn) begin
      case (reg_sel)
        2'd0:    hrdata[DATA_BITS-1:0] = rx_head;
        2'd1:    hrdata[15:0] = status;
        2'd2:    hrdata[19:0] = ctrl_q;
        default: hrdata = '0;
      endcase
    end
  end

  assign irq = (ctrl_q[18] & ~rx_empty) | (ctrl_q[19] & tx_empty) | ovf_q | ferr_q;

endmodule

// File: tb/tb_uart_ahb_fifo.sv
// tb/tb_uart_ahb_fifo.sv - scoreboard bench for uart_ahb_fifo
module tb_uart_ahb_fifo;

  localparam logic [31:0] A_DATA = 32'h0;
  localparam logic [31:0] A_STAT = 32'h4;
  localparam logic [31:0] A_CTRL = 32'h8;
  localparam logic [31:0] A_CLR  = 32'hC;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] hwdata = '0;
  logic [31:0] haddr = '0;
  logic        hsel = 1'b0;
  logic        hwrite = 1'b0;
  logic        hready, hresp, tx_pin, irq;
  logic [31:0] hrdata;
  logic        rx_drv = 1'b1;
  logic        loop_en = 1'b0;
  wire         rx_pin = loop_en ? tx_pin : rx_drv;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [7:0]  exp_q[$];

  always #5 clk = ~clk;

  uart_ahb_fifo #(.FIFO_DEPTH(4), .DEFAULT_DIV(16'd868), .DATA_BITS(8)) dut (
    .clk(clk), .rstn(rstn), .hwdata(hwdata), .haddr(haddr), .hsel(hsel),
    .hwrite(hwrite), .hready(hready), .hresp(hresp), .hrdata(hrdata),
    .rx_pin(rx_pin), .tx_pin(tx_pin), .irq(irq)
  );

  task automatic ahb_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    hsel = 1'b1; hwrite = 1'b1; haddr = a; hwdata = d;
    @(negedge clk);
    hsel = 1'b0; hwrite = 1'b0;
  endtask

  task automatic ahb_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    hsel = 1'b1; hwrite = 1'b0; haddr = a;
    #1 d = hrdata;
    @(negedge clk);
    hsel = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    hsel = 1'b1; hwrite = 1'b0; haddr = A_STAT;
    #1;
    n_checks++; if (tx_pin !== 1'b1) begin n_fail++; $display("FAIL reset_tx_pin: got %b expected 1", tx_pin); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", irq); end
    n_checks++; if (hrdata !== 32'h0) begin n_fail++; $display("FAIL reset_hrdata: got %h expected 0", hrdata); end
    hsel = 1'b0;
    @(negedge clk) rstn = 1'b1;
    n_checks++; if (hready !== 1'b1 || hresp !== 1'b0) begin n_fail++; $display("FAIL hready_hresp: got %b%b expected 10", hready, hresp); end
    ahb_read(A_STAT, d);
    n_checks++; if (d !== 32'h0000_000A) begin n_fail++; $display("FAIL reset_status: got %h expected 0000000a", d); end
    ahb_read(A_CTRL, d);
    n_checks++; if (d !== 32'd868) begin n_fail++; $display("FAIL reset_ctrl: got %h expected %h", d, 32'd868); end
    ahb_read(A_DATA, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL empty_data_read: got %h expected 0", d); end
    ahb_read(A_STAT, d);
    n_checks++; if (d !== 32'h0000_000A) begin n_fail++; $display("FAIL empty_read_unchanged: got %h expected 0000000a", d); end
    ahb_read(A_CLR, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL clr_read: got %h expected 0", d); end
  endtask

  task automatic test_tx_pattern();
    logic [31:0] d;
    logic [9:0]  frame;
    logic        found;
    frame = {1'b1, 8'hA5, 1'b0};
    found = 1'b0;
    ahb_write(A_CTRL, 32'd4);
    ahb_write(A_DATA, 32'hA5);
    for (int i = 0; i < 2 && !found; i++) begin
      @(posedge clk); #1;
      if (tx_pin === 1'b0) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_fail++; $display("FAIL tx_start_latency: got no start bit, expected start within 2 cycles");
    end else begin
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (tx_pin !== frame[0]) begin n_fail++; $display("FAIL tx_bit0: got %b expected %b", tx_pin, frame[0]); end
      for (int k = 1; k < 10; k++) begin
        repeat (4) @(posedge clk);
        #1;
        n_checks++; if (tx_pin !== frame[k]) begin n_fail++; $display("FAIL tx_bit%0d: got %b expected %b", k, tx_pin, frame[k]); end
      end
    end
    repeat (10) @(posedge clk);
    ahb_read(A_STAT, d);
    n_checks++; if (d !== 32'h0000_000A) begin n_fail++; $display("FAIL tx_idle_status: got %h expected 0000000a", d); end
  endtask

  task automatic test_loopback();
    logic [31:0] d;
    logic        s [300];
    int          f0;
    logic [7:0]  e;
    loop_en = 1'b1;
    ahb_write(A_CTRL, 32'h0001_0008);
    fork
      begin
        exp_q.push_back(8'h00); ahb_write(A_DATA, 32'h00);
        exp_q.push_back(8'hFF); ahb_write(A_DATA, 32'hFF);
        exp_q.push_back(8'h3C); ahb_write(A_DATA, 32'h3C);
      end
      begin
        for (int i = 0; i < 300; i++) begin
          @(posedge clk); #1 s[i] = tx_pin;
        end
      end
    join
    f0 = -1;
    for (int i = 0; i < 20; i++) if (f0 < 0 && s[i] === 1'b0) f0 = i;
    n_checks++;
    if (f0 < 0) begin
      n_fail++; $display("FAIL loop_start: got no start bit, expected one within 20 cycles");
    end else begin
      n_checks++; if (s[f0+87] !== 1'b1 || s[f0+88] !== 1'b0) begin n_fail++; $display("FAIL b2b_gap1: got %b%b expected 10", s[f0+87], s[f0+88]); end
      n_checks++; if (s[f0+175] !== 1'b1 || s[f0+176] !== 1'b0) begin n_fail++; $display("FAIL b2b_gap2: got %b%b expected 10", s[f0+175], s[f0+176]); end
    end
    repeat (80) @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      ahb_read(A_DATA, d);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
      n_checks++; if (d !== {24'h0, e}) begin n_fail++; $display("FAIL loop_data%0d: got %h expected %h", i, d, e); end
    end
    ahb_read(A_STAT, d);
    n_checks++; if (d !== 32'h0000_000A) begin n_fail++; $display("FAIL loop_status: got %h expected 0000000a", d); end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    logic [7:0]  e;
    loop_en = 1'b1;
    ahb_write(A_CTRL, 32'd8);
    for (int i = 0; i < 5; i++) begin
      e = 8'(8'h11 * (i + 1));
      if (i < 4) exp_q.push_back(e);
      ahb_write(A_DATA, {24'h0, e});
    end
    repeat (520) @(posedge clk);
    ahb_read(A_STAT, d);
    n_checks++; if (d !== 32'h0000_0426) begin n_fail++; $display("FAIL ovf_status: got %h expected 00000426", d); end
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL ovf_irq: got %b expected 1", irq); end
    ahb_write(A_CLR, 32'h1);
    ahb_read(A_STAT, d);
    n_checks++; if (d !== 32'h0000_0406) begin n_fail++; $display("FAIL ovf_clr_status: got %h expected 00000406", d); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL ovf_clr_irq: got %b expected 0", irq); end
    for (int i = 0; i < 4; i++) begin
      ahb_read(A_DATA, d);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
      n_checks++; if (d !== {24'h0, e}) begin n_fail++; $display("FAIL ovf_data%0d: got %h expected %h", i, d, e); end
    end
  endtask

  task automatic test_glitch();
    logic [31:0] d;
    loop_en = 1'b0;
    ahb_write(A_CTRL, 32'd16);
    @(negedge clk) rx_drv = 1'b0;
    repeat (2) @(negedge clk);
    rx_drv = 1'b1;
    repeat (60) @(posedge clk);
    ahb_read(A_STAT, d);
    n_checks++; if (d !== 32'h0000_000A) begin n_fail++; $display("FAIL glitch_status: got %h expected 0000000a", d); end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    @(negedge clk) rx_drv = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (16) @(negedge clk);
    end
    rx_drv = stop;
    repeat (16) @(negedge clk);
    rx_drv = 1'b1;
    repeat (16) @(negedge clk);
  endtask

  task automatic test_frame_err();
    logic [31:0] d;
    logic [7:0]  e;
    loop_en = 1'b0;
    send_frame(8'h55, 1'b0);
    ahb_read(A_STAT, d);
    n_checks++; if (d !== 32'h0000_008A) begin n_fail++; $display("FAIL ferr_status: got %h expected 0000008a", d); end
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL ferr_irq: got %b expected 1", irq); end
    ahb_write(A_CLR, 32'h4);
    ahb_read(A_STAT, d);
    n_checks++; if (d !== 32'h0000_000A) begin n_fail++; $display("FAIL ferr_clr_status: got %h expected 0000000a", d); end
    exp_q.push_back(8'h96);
    send_frame(8'h96, 1'b1);
    ahb_read(A_DATA, d);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
    n_checks++; if (d !== {24'h0, e}) begin n_fail++; $display("FAIL rx_after_ferr: got %h expected %h", d, e); end
  endtask

  task automatic test_wrap();
    logic [31:0] d;
    logic [7:0]  v, e;
    loop_en = 1'b1;
    ahb_write(A_CTRL, 32'd8);
    for (int r = 0; r < 20; r++) begin
      for (int j = 0; j < 4; j++) begin
        v = 8'($urandom);
        exp_q.push_back(v);
        ahb_write(A_DATA, {24'h0, v});
      end
      repeat (360) @(posedge clk);
      for (int j = 0; j < 4; j++) begin
        ahb_read(A_DATA, d);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
        n_checks++; if (d !== {24'h0, e}) begin n_fail++; $display("FAIL wrap_r%0d_b%0d: got %h expected %h", r, j, d, e); end
      end
    end
    ahb_read(A_STAT, d);
    n_checks++; if (d !== 32'h0000_000A) begin n_fail++; $display("FAIL wrap_status: got %h expected 0000000a", d); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    loop_en = 1'b0;
    ahb_write(A_CTRL, 32'd8);
    ahb_write(A_DATA, 32'h00);
    repeat (20) @(posedge clk);
    #1;
    n_checks++; if (tx_pin !== 1'b0) begin n_fail++; $display("FAIL mid_frame_low: got %b expected 0", tx_pin); end
    #2 rstn = 1'b0;
    #1;
    n_checks++; if (tx_pin !== 1'b1) begin n_fail++; $display("FAIL async_reset_tx: got %b expected 1", tx_pin); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL async_reset_irq: got %b expected 0", irq); end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    ahb_read(A_STAT, d);
    n_checks++; if (d !== 32'h0000_000A) begin n_fail++; $display("FAIL post_reset_status: got %h expected 0000000a", d); end
  endtask

  initial begin
    test_reset();
    test_tx_pattern();
    test_loopback();
    test_overflow();
    test_glitch();
    test_frame_err();
    test_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000000;
    $display("FAIL watchdog: simulation did not complete within the time limit");
    $fatal(1);
  end

endmodule
